idelay_tap_ctrl: RTL

IDELAY_TAP_CTRL -- requirements
Module: idelay_tap_ctrl

---
 rtl/idelay_tap_ctrl.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/idelay_tap_ctrl.sv
// Tap-load sequencer for IDELAY lines: EN_VTC off, LOAD, settle, readback check, EN_VTC on.
// Aborts to FINISH if IDELAYCTRL ready drops during the active part of the sequence.
module idelay_tap_ctrl #(
  parameter int NUM_CH   = 4,
  parameter int TAP_W    = 9,
  parameter int MAX_TAP  = 511,
  parameter int VTC_WAIT = 16
) (
  input  logic                    ref_clk_400m,
  input  logic                    reset_n,
  input  logic                    i_idelay_rdy,
  input  logic                    i_req,
  input  logic [NUM_CH-1:0]       i_ch_mask,
  input  logic [NUM_CH*TAP_W-1:0] i_cnt_value,
  input  logic [NUM_CH*TAP_W-1:0] i_cnt_value_out,
  output logic [NUM_CH*TAP_W-1:0] o_cnt_value,
  output logic [NUM_CH-1:0]       o_load,
  output logic [NUM_CH-1:0]       o_en_vtc,
  output logic                    o_busy,
  output logic                    o_done,
  output logic [NUM_CH-1:0]       o_err_mask,
  output logic                    o_abort
);

  typedef enum logic [2:0] {
    IDLE, WAIT_RDY, VTC_OFF, LOAD, SETTLE, VERIFY, FINISH
  } state_t;

  state_t                    state_q, state_d;
  logic [7:0]                cnt_q, cnt_d;
  logic [NUM_CH-1:0]         mask_q, mask_d;
  logic [NUM_CH*TAP_W-1:0]   taps_q, taps_d;
  logic [NUM_CH-1:0]         err_q, err_d;
  logic                      abort_q, abort_d;
  logic [NUM_CH*TAP_W-1:0]   clamped;
  logic [NUM_CH-1:0]         mismatch;

  always_ff @(posedge ref_clk_400m or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      mask_q  <= '0;
      taps_q  <= '0;
      err_q   <= '0;
      abort_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      mask_q  <= mask_d;
      taps_q  <= taps_d;
      err_q   <= err_d;
      abort_q <= abort_d;
    end
  end

  always_comb begin
    logic [TAP_W-1:0] tap;
    tap      = '0;
    clamped  = '0;
    mismatch = '0;
    for (int unsigned n = 0; n < NUM_CH; n++) begin
      tap = i_cnt_value[n*TAP_W +: TAP_W];
      clamped[n*TAP_W +: TAP_W] = (tap > TAP_W'(MAX_TAP)) ? TAP_W'(MAX_TAP) : tap;
      mismatch[n] = (i_cnt_value_out[n*TAP_W +: TAP_W] != taps_q[n*TAP_W +: TAP_W]);
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    mask_d  = mask_q;
    taps_d  = taps_q;
    err_d   = err_q;
    abort_d = abort_q;
    unique case (state_q)
      IDLE: begin
        if (i_req) begin
          mask_d  = i_ch_mask;
          taps_d  = clamped;
          err_d   = '0;
          abort_d = 1'b0;
          if (i_ch_mask == '0) begin
            state_d = FINISH;
          end else if (!i_idelay_rdy) begin
            state_d = WAIT_RDY;
          end else begin
            state_d = VTC_OFF;
            cnt_d   = 8'(VTC_WAIT - 1);
          end
        end
      end
      WAIT_RDY: begin
        if (i_idelay_rdy) begin
          state_d = VTC_OFF;
          cnt_d   = 8'(VTC_WAIT - 1);
        end
      end
      VTC_OFF: begin
        if (!i_idelay_rdy) begin
          state_d = FINISH;
          abort_d = 1'b1;
        end else if (cnt_q == '0) begin
          state_d = LOAD;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      LOAD: begin
        if (!i_idelay_rdy) begin
          state_d = FINISH;
          abort_d = 1'b1;
        end else begin
          state_d = SETTLE;
          cnt_d   = 8'd1;
        end
      end
      SETTLE: begin
        if (!i_idelay_rdy) begin
          state_d = FINISH;
          abort_d = 1'b1;
        end else if (cnt_q == '0) begin
          state_d = VERIFY;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      VERIFY: begin
        state_d = FINISH;
        if (!i_idelay_rdy) abort_d = 1'b1;
        else               err_d   = mask_q & mismatch;
      end
      FINISH:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    o_en_vtc = '1;
    o_load   = '0;
    o_busy   = 1'b0;
    o_done   = 1'b0;
    unique case (state_q)
      WAIT_RDY:                o_busy = 1'b1;
      VTC_OFF, SETTLE, VERIFY: begin
        o_busy   = 1'b1;
        o_en_vtc = ~mask_q;
      end
      LOAD: begin
        o_busy   = 1'b1;
        o_en_vtc = ~mask_q;
        o_load   = mask_q;
      end
      FINISH:  o_done = 1'b1;
      default: ;
    endcase
  end

  assign o_cnt_value = taps_q;
  assign o_err_mask  = err_q;
  assign o_abort     = abort_q;

endmodule
